// File: rtl/c_serial_encode_pkg.sv
// Shared helpers and state encoding for the serial vector-to-index encoder.
package c_serial_encode_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Ceiling log2, never less than 1 so single-port configurations still get an index bit.
   function automatic int clogb(input int value);
      int result;
      result = 1;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/c_prio_lowest.sv
// Lowest-set-bit finder: one-hot of the leftmost (lowest position) set bit plus its binary position.
module c_prio_lowest #(
   parameter int num_ports = 8,
   parameter int width     = 3
) (
   input  logic [0:num_ports-1] vec,
   output logic [0:num_ports-1] onehot,
   output logic [width-1:0]     index
);

   logic found;

   always_comb begin
      onehot = '0;
      index  = '0;
      found  = 1'b0;
      for (int i = 0; i < num_ports; i++) begin
         if (!found && vec[i]) begin
            found     = 1'b1;
            onehot[i] = 1'b1;
            index     = width'(i);
         end
      end
   end

endmodule

// File: rtl/c_serial_encode.sv
// Serializes a multi-hot port vector into one rotated binary index per output beat,
// lowest position first, flagging the final index of each vector.
//
// state | meaning
// IDLE  | no pending bits; in_ready high, out_valid low
// BUSY  | pending holds unsent bits; one index offered per cycle
module c_serial_encode
   import c_serial_encode_pkg::*;
#(
   parameter int num_ports = 8,
   parameter int offset    = 0,
   parameter int width     = clogb(num_ports)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [0:num_ports-1] in_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [0:width-1]     out_index,
   output logic                 out_last
);

   localparam int unsigned off_mod = offset % num_ports;

   state_t                 state, state_nxt;
   logic [0:num_ports-1]   pending, pending_nxt;
   logic [0:num_ports-1]   low_onehot;
   logic [width-1:0]       p_min;
   logic [width:0]         sum, rot;
   logic                   busy, beat, load;

   c_prio_lowest #(
      .num_ports (num_ports),
      .width     (width)
   ) u_prio (
      .vec    (pending),
      .onehot (low_onehot),
      .index  (p_min)
   );

   // Sum is one bit wider than the index so a single conditional subtract performs the mod.
   always_comb begin
      sum = {1'b0, p_min} + (width+1)'(off_mod);
      rot = sum;
      if (sum >= (width+1)'(num_ports)) begin
         rot = sum - (width+1)'(num_ports);
      end
   end

   assign busy      = (state == BUSY);
   assign out_valid = busy;
   assign out_last  = busy && (pending == low_onehot);
   assign out_index = busy ? width'(rot) : '0;
   assign beat      = busy && out_ready;
   assign in_ready  = !busy || (beat && out_last);
   assign load      = in_valid && in_ready;

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      if (beat) begin
         pending_nxt = pending & ~low_onehot;
         if (out_last) begin
            state_nxt = IDLE;
         end
      end
      if (load) begin
         pending_nxt = in_vec;
         state_nxt   = (|in_vec) ? BUSY : IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         pending <= '0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
      end
   end

endmodule
